// File: rtl/countdown_timer_ctrl.sv
// Sequencing controller for a binary down-counter: start/pause/clear handling,
// reload-on-expiry and a tick-timed alarm.
module countdown_timer_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] preset,
    output logic             cnt_ce,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_l,
    input  logic [WIDTH-1:0] cnt_q,
    input  logic             cnt_thresh0,
    output logic             running,
    output logic             paused,
    output logic             done_pulse,
    output logic             alarm
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSED,
        S_ALARM
    } state_t;

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t           state;
    logic [WIDTH-1:0] preset_q;
    logic [7:0]       alarm_cnt;
    logic             expired;
    logic             preset_nz;

    // Q readback backs up THRESH0 so a stuck flag can never let the count wrap.
    always_comb begin
        expired   = cnt_thresh0 | (cnt_q == '0);
        preset_nz = |preset;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            preset_q  <= '0;
            alarm_cnt <= '0;
        end else begin
            case (state)
                S_CLEAR: state <= S_IDLE;
                S_IDLE: begin
                    if (clear) begin
                        state <= S_CLEAR;
                    end else if (start && preset_nz) begin
                        preset_q <= preset;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: state <= clear ? S_CLEAR : S_RUN;
                S_RUN: begin
                    if (clear) begin
                        state <= S_CLEAR;
                    end else if (expired) begin
                        if (auto_reload) begin
                            state <= S_LOAD;
                        end else begin
                            alarm_cnt <= '0;
                            state     <= S_ALARM;
                        end
                    end else if (pause) begin
                        state <= S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (clear) begin
                        state <= S_CLEAR;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end
                S_ALARM: begin
                    if (clear) begin
                        state <= S_CLEAR;
                    end else if (start) begin
                        if (preset_nz) begin
                            preset_q <= preset;
                            state    <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (pause) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (alarm_cnt == ALARM_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            alarm_cnt <= alarm_cnt + 8'd1;
                        end
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    always_comb begin
        cnt_ce     = 1'b0;
        cnt_load   = 1'b0;
        cnt_l      = '0;
        running    = 1'b0;
        paused     = 1'b0;
        done_pulse = 1'b0;
        alarm      = 1'b0;
        if (!rst) begin
            case (state)
                S_CLEAR: begin
                    cnt_load = 1'b1;
                    cnt_ce   = 1'b1;
                end
                S_LOAD: begin
                    cnt_load = 1'b1;
                    cnt_ce   = 1'b1;
                    cnt_l    = preset_q;
                end
                S_RUN: begin
                    running    = 1'b1;
                    cnt_ce     = tick & ~expired & ~pause & ~clear;
                    done_pulse = expired & ~clear;
                end
                S_PAUSED: paused = 1'b1;
                S_ALARM:  alarm  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
